// File: rtl/biu_pkg.sv
`default_nettype none
// biu_pkg -- shared BIU definitions: status codes, direction, programming address, burst decode.
// Revision: 1.0
package biu_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_CONT  = 2'b01,
    ST_IDLE  = 2'b10,
    ST_BUSY  = 2'b11
  } biu_status_e;

  localparam logic        DIR_READ          = 1'b0;
  localparam logic        DIR_WRITE         = 1'b1;
  localparam logic [31:0] PROG_ADDR_DEFAULT = 32'h3FFF_FFFF;
  localparam logic [8:0]  CTRL_IDLE         = 9'h100;

  // Codes 0..6 select 2^code beats; code 7 is a full 256-beat page.
  function automatic logic [8:0] burst_decode(input logic [2:0] code);
    return (code == 3'd7) ? 9'd256 : (9'd1 << code);
  endfunction

endpackage
`default_nettype wire

// File: rtl/biu_beat_counter.sv
`default_nettype none
// biu_beat_counter -- counts accepted beats of a burst and holds the programmed burst code.
// Revision: 1.0
module biu_beat_counter
  import biu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       prog,
  input  logic       ready,
  input  logic [2:0] code,
  output logic [8:0] count,
  output logic       done,
  output logic [8:0] burst_len
);

  logic [8:0] count_d, count_q;
  logic [2:0] code_d, code_q;
  logic [8:0] count_inc;

  always_comb begin
    count_inc = count_q + 9'd1;
    count_d   = count_q;
    code_d    = code_q;
    if (ready) begin
      if (start) begin
        count_d = 9'd1;
      end else if (cont) begin
        count_d = count_inc;
      end
      if (prog) begin
        code_d = code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 9'd0;
      code_q  <= 3'd0;
    end else begin
      count_q <= count_d;
      code_q  <= code_d;
    end
  end

  assign burst_len = burst_decode(code_q);
  assign count     = count_q;
  assign done      = ready & ((start & (burst_len == 9'd1)) |
                              (cont & (count_inc == burst_len)));

endmodule
`default_nettype wire

// File: rtl/biu_arbiter.sv
`default_nettype none
// biu_arbiter -- two-master arbiter in front of biu_controls with burst tracking and preemption.
// Revision: 1.0
module biu_arbiter
  import biu_pkg::*;
#(
  parameter int          MAX_BURSTS = 4,
  parameter logic [31:0] PROG_ADDR  = PROG_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [8:0]  Ctrl0,
  input  logic [8:0]  Ctrl1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] Data0,
  input  logic [31:0] Data1,
  input  logic        Ready,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic [8:0]  Control,
  output logic [31:0] AddrIn,
  output logic [31:0] DataIn,
  output logic        Ready0,
  output logic        Ready1,
  output logic [8:0]  BurstLen
);

  typedef enum logic [1:0] {ARB, OWN, BURST, PROG} state_e;

  localparam int                   BURSTS_W   = $clog2(MAX_BURSTS + 1);
  localparam logic [BURSTS_W-1:0]  BURSTS_MAX = BURSTS_W'(MAX_BURSTS);
  localparam logic [BURSTS_W-1:0]  BURSTS_ONE = BURSTS_W'(1);

  state_e              state_d, state_q;
  logic                gnt0_d, gnt0_q, gnt1_d, gnt1_q;
  logic                owner_d, owner_q;
  logic                last_d, last_q;
  logic [BURSTS_W-1:0] bursts_d, bursts_q;

  logic       own_req, other_req, prog_hit, release_own, enter_prog;
  logic       bc_start, bc_cont, bc_prog, bc_done;
  logic [1:0] own_status;
  logic [8:0] bc_count;

  always_comb begin
    Control = CTRL_IDLE;
    AddrIn  = 32'd0;
    DataIn  = 32'd0;
    if (gnt0_q) begin
      Control = Ctrl0;
      AddrIn  = Addr0;
      DataIn  = Data0;
    end else if (gnt1_q) begin
      Control = Ctrl1;
      AddrIn  = Addr1;
      DataIn  = Data1;
    end
  end

  assign Ready0     = gnt0_q & Ready;
  assign Ready1     = gnt1_q & Ready;
  assign Gnt0       = gnt0_q;
  assign Gnt1       = gnt1_q;
  assign own_req    = owner_q ? Req1 : Req0;
  assign other_req  = owner_q ? Req0 : Req1;
  assign own_status = Control[8:7];
  assign prog_hit   = (AddrIn == PROG_ADDR) && (Control[0] == DIR_WRITE);

  // Leaving OWN wins over any beat presented in the same cycle.
  assign release_own = (state_q == OWN) && (!own_req || (bursts_q == BURSTS_MAX));
  assign bc_start    = (state_q == OWN) && !release_own && (own_status == ST_START) && !prog_hit;
  assign enter_prog  = (state_q == OWN) && !release_own && (own_status == ST_START) && prog_hit && Ready;
  assign bc_cont     = (state_q == BURST) && (own_status == ST_CONT) && (bc_count != BurstLen);
  assign bc_prog     = (state_q == PROG) && ((own_status == ST_START) || (own_status == ST_CONT));

  biu_beat_counter u_beat_counter (
    .clk       (Clk),
    .rst_n     (Rst),
    .start     (bc_start),
    .cont      (bc_cont),
    .prog      (bc_prog),
    .ready     (Ready),
    .code      (DataIn[2:0]),
    .count     (bc_count),
    .done      (bc_done),
    .burst_len (BurstLen)
  );

  always_comb begin
    state_d  = state_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    owner_d  = owner_q;
    last_d   = last_q;
    bursts_d = bursts_q;
    // Completed bursts only count toward preemption while the other master keeps asking.
    if (!other_req) begin
      bursts_d = '0;
    end else if (bc_done && (bursts_q != BURSTS_MAX)) begin
      bursts_d = bursts_q + BURSTS_ONE;
    end
    case (state_q)
      ARB: begin
        bursts_d = '0;
        if (Req0 && (!Req1 || last_q)) begin
          gnt0_d  = 1'b1;
          owner_d = 1'b0;
          last_d  = 1'b0;
          state_d = OWN;
        end else if (Req1) begin
          gnt1_d  = 1'b1;
          owner_d = 1'b1;
          last_d  = 1'b1;
          state_d = OWN;
        end
      end
      OWN: begin
        if (release_own) begin
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          state_d = ARB;
        end else if (enter_prog) begin
          state_d = PROG;
        end else if (bc_start && Ready && !bc_done) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (bc_done) begin
          state_d = OWN;
        end
      end
      PROG: begin
        if (bc_prog && Ready) begin
          state_d = OWN;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= ARB;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      bursts_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      bursts_q <= bursts_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_biu_arbiter.sv
`default_nettype none
// tb_biu_arbiter -- directed self-checking bench for biu_arbiter.
// Revision: 1.0
module tb_biu_arbiter;

  localparam logic [1:0]  S_START = 2'b00;
  localparam logic [1:0]  S_CONT  = 2'b01;
  localparam logic [1:0]  S_IDLE  = 2'b10;
  localparam logic [1:0]  S_BUSY  = 2'b11;
  localparam logic [31:0] P_ADDR  = 32'h3FFF_FFFF;

  logic        Clk = 1'b0;
  logic        Rst, Req0, Req1, Ready;
  logic [8:0]  Ctrl0, Ctrl1;
  logic [31:0] Addr0, Addr1, Data0, Data1;
  logic        Gnt0, Gnt1, Ready0, Ready1;
  logic [8:0]  Control, BurstLen;
  logic [31:0] AddrIn, DataIn;

  int checks = 0;
  int errors = 0;

  biu_arbiter #(.MAX_BURSTS(4), .PROG_ADDR(32'h3FFF_FFFF)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Req0     (Req0),
    .Req1     (Req1),
    .Ctrl0    (Ctrl0),
    .Ctrl1    (Ctrl1),
    .Addr0    (Addr0),
    .Addr1    (Addr1),
    .Data0    (Data0),
    .Data1    (Data1),
    .Ready    (Ready),
    .Gnt0     (Gnt0),
    .Gnt1     (Gnt1),
    .Control  (Control),
    .AddrIn   (AddrIn),
    .DataIn   (DataIn),
    .Ready0   (Ready0),
    .Ready1   (Ready1),
    .BurstLen (BurstLen)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [8:0] ctl(input logic [1:0] st, input logic wr);
    return {st, 6'd0, wr};
  endfunction

  // One master-0 cycle: drive the beat, then let the clock edge sample it.
  task automatic m0(input logic [1:0] st, input logic wr, input logic [31:0] a,
                    input logic [31:0] d, input logic rdy);
    Ctrl0 = ctl(st, wr);
    Addr0 = a;
    Data0 = d;
    Ready = rdy;
    tick();
  endtask

  task automatic prog0(input logic [31:0] d);
    m0(S_START, 1'b1, P_ADDR, 32'd0, 1'b1);
    m0(S_CONT, 1'b1, 32'd0, d, 1'b1);
    Ctrl0 = ctl(S_IDLE, 1'b0);
    Ready = 1'b0;
  endtask

  task automatic do_reset();
    Rst   = 1'b0;
    Req0  = 1'b0;
    Req1  = 1'b0;
    Ctrl0 = ctl(S_IDLE, 1'b0);
    Ctrl1 = ctl(S_IDLE, 1'b0);
    Addr0 = 32'd0;
    Addr1 = 32'd0;
    Data0 = 32'd0;
    Data1 = 32'd0;
    Ready = 1'b0;
    tick();
    Rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values with noisy inputs present
    Rst = 1'b0; Req0 = 1'b1; Req1 = 1'b1; Ready = 1'b1;
    Ctrl0 = 9'h0AA; Ctrl1 = 9'h055;
    Addr0 = 32'hDEAD_0000; Addr1 = 32'hDEAD_1111;
    Data0 = 32'hBEEF_0000; Data1 = 32'hBEEF_1111;
    tick();
    tick();
    check_val("rst_gnt",    {Gnt1, Gnt0}, 2'b00);
    check_val("rst_ready",  {Ready1, Ready0}, 2'b00);
    check_val("rst_ctrl",   Control, 9'h100);
    check_val("rst_addr",   AddrIn, 32'd0);
    check_val("rst_data",   DataIn, 32'd0);
    check_val("rst_blen",   BurstLen, 9'd1);

    // Single requester granted one cycle later, mux follows owner
    do_reset();
    Req0 = 1'b1;
    #1;
    check_val("pre_grant", Gnt0, 1'b0);
    tick();
    check_val("grant0", {Gnt1, Gnt0}, 2'b01);
    Ctrl0 = 9'h1A5; Addr0 = 32'h1234_5678; Data0 = 32'hCAFE_0001;
    Ctrl1 = 9'h0FF; Ready = 1'b1;
    #1;
    check_val("own_ctrl",   Control, 9'h1A5);
    check_val("own_addr",   AddrIn, 32'h1234_5678);
    check_val("own_data",   DataIn, 32'hCAFE_0001);
    check_val("own_ready1", Ready1, 1'b0);
    check_val("own_ready0", Ready0, 1'b1);
    Ready = 1'b0;
    tick();

    // Program length 4, burst holds grant across Req0 drop
    prog0(32'h0503_043A);
    check_val("prog_len4", BurstLen, 9'd4);
    m0(S_START, 1'b0, 32'h100, 32'd0, 1'b1);
    m0(S_CONT,  1'b0, 32'h104, 32'd0, 1'b1);
    Req0 = 1'b0;
    m0(S_CONT,  1'b0, 32'h108, 32'd0, 1'b0);
    check_val("hold_wait", Gnt0, 1'b1);
    m0(S_CONT,  1'b0, 32'h108, 32'd0, 1'b1);
    check_val("hold_b3", Gnt0, 1'b1);
    m0(S_CONT,  1'b0, 32'h10C, 32'd0, 1'b1);
    check_val("hold_b4", Gnt0, 1'b1);
    m0(S_IDLE,  1'b0, 32'd0, 32'd0, 1'b0);
    check_val("release", Gnt0, 1'b0);
    check_val("release_ctl", Control, 9'h100);

    // Both request: master 0 first, handover through one ARB cycle
    do_reset();
    Req0 = 1'b1; Req1 = 1'b1;
    Ctrl0 = 9'h1AA; Ctrl1 = 9'h1D5;
    tick();
    check_val("both_gnt",  {Gnt1, Gnt0}, 2'b01);
    check_val("both_ctrl", Control, 9'h1AA);
    Req0 = 1'b0;
    tick();
    check_val("handover_arb", {Gnt1, Gnt0}, 2'b00);
    tick();
    check_val("handover_gnt1", {Gnt1, Gnt0}, 2'b10);
    check_val("handover_ctrl", Control, 9'h1D5);

    // Preemption after 4 bursts of length 2
    do_reset();
    Req0 = 1'b1; Req1 = 1'b1;
    tick();
    prog0(32'd1);
    check_val("pre_len2", BurstLen, 9'd2);
    for (int b = 0; b < 4; b++) begin
      m0(S_START, 1'b0, 32'h400 + 32'(b * 8), 32'd0, 1'b1);
      m0(S_CONT,  1'b0, 32'h404 + 32'(b * 8), 32'd0, 1'b1);
      if (b == 2) check_val("pre_not_yet", {Gnt1, Gnt0}, 2'b01);
    end
    Ctrl0 = ctl(S_IDLE, 1'b0);
    Ready = 1'b0;
    #1;
    check_val("pre_own",  {Gnt1, Gnt0}, 2'b01);
    tick();
    check_val("pre_arb",  {Gnt1, Gnt0}, 2'b00);
    tick();
    check_val("pre_gnt1", {Gnt1, Gnt0}, 2'b10);

    // Full-page burst with BUSY cycles interleaved
    do_reset();
    Req0 = 1'b1;
    tick();
    prog0(32'd7);
    check_val("page_len", BurstLen, 9'd256);
    m0(S_START, 1'b0, 32'h8000, 32'd0, 1'b1);
    Req0 = 1'b0;
    for (int j = 0; j < 260; j++) begin
      if (j == 259) check_val("page_pending", Gnt0, 1'b1);
      if (j == 10 || j == 50 || j == 100 || j == 200 || j == 254)
        m0(S_BUSY, 1'b0, 32'h8000, 32'd0, 1'b1);
      else
        m0(S_CONT, 1'b0, 32'h8000, 32'd0, 1'b1);
    end
    check_val("page_done_own", Gnt0, 1'b1);
    m0(S_IDLE, 1'b0, 32'd0, 32'd0, 1'b0);
    check_val("page_release", Gnt0, 1'b0);

    // Reset during beat 3 of 8
    do_reset();
    Req0 = 1'b1;
    tick();
    prog0(32'd3);
    check_val("mid_len8", BurstLen, 9'd8);
    m0(S_START, 1'b0, 32'h200, 32'h11, 1'b1);
    m0(S_CONT,  1'b0, 32'h204, 32'h22, 1'b1);
    Ctrl0 = ctl(S_CONT, 1'b0); Addr0 = 32'h208; Data0 = 32'h33; Ready = 1'b1;
    Rst = 1'b0;
    tick();
    check_val("mid_gnt",   {Gnt1, Gnt0}, 2'b00);
    check_val("mid_ready", {Ready1, Ready0}, 2'b00);
    check_val("mid_ctrl",  Control, 9'h100);
    check_val("mid_addr",  AddrIn, 32'd0);
    check_val("mid_data",  DataIn, 32'd0);
    check_val("mid_blen",  BurstLen, 9'd1);
    Rst = 1'b1;
    Req0 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
